// File: rtl/fifo_rr_arbiter_pkg.sv
// Purpose : shared sizing constants, the requester-index type and a wrap helper for the arbiter slice.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package fifo_arb_pkg;

  localparam int NUM_REQ_MAX   = 16;
  localparam int BURST_LEN_MAX = 16;
  localparam int ARB_ID_W      = $clog2(NUM_REQ_MAX);
  localparam int BURST_CNT_W   = $clog2(BURST_LEN_MAX);

  // Requester index wide enough for the largest supported requester count.
  typedef logic [ARB_ID_W-1:0] arb_id_t;

  // Next index in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_if.sv
// Purpose : bundles the requester-side and FIFO-side valid/ready signals of the arbiter.
// Latency : n/a (wiring only).
// Backpr. : n/a; req_ready and in_ready carry the backpressure.
// Ports   : req_valid/req_packet in, req_ready out (requester side);
//           in_valid/packet_in/grant_id out, in_ready in (FIFO side).
//           master = arbiter view, slave = producer/FIFO view.
interface fifo_rr_arbiter_if #(
  parameter type PACKET_T = logic [31:0],
  parameter int  NUM_REQ  = 4,
  parameter int  ID_W     = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  PACKET_T            req_packet [NUM_REQ];
  logic               in_valid;
  logic               in_ready;
  PACKET_T            packet_in;
  logic [ID_W-1:0]    grant_id;

  modport master (
    input  req_valid, req_packet, in_ready,
    output req_ready, in_valid, packet_in, grant_id
  );

  modport slave (
    output req_valid, req_packet, in_ready,
    input  req_ready, in_valid, packet_in, grant_id
  );

endinterface

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Purpose : first set request at or after a start index, wrapping around the ring.
// Latency : purely combinational.
// Backpr. : none; the caller decides whether the pick is used.
// Ports   : req_i request vector, start_i search origin; idx_o picked index, found_o any request set.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  always_comb begin
    int cand;
    idx_o   = '0;
    found_o = 1'b0;
    cand    = int'(start_i);
    // Walk the ring once from start_i; the first hit wins.
    for (int i = 0; i < N; i++) begin
      if (!found_o && req_i[cand[W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[W-1:0];
      end
      cand = wrap_inc(cand, N);
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Purpose : round-robin arbiter (with optional burst hold) feeding one FIFO input port.
// Latency : one cycle; a packet accepted at edge N is on packet_in from N.
// Backpr. : a held packet (in_valid & !in_ready) stalls all requesters; drain and load share an edge.
// Ports   : clock_i, reset_ni (async active-low);
//           bus (master modport) carries the requester and FIFO handshakes.
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter type PACKET_T  = logic [31:0],
  parameter int  NUM_REQ   = 4,   // 2..NUM_REQ_MAX
  parameter int  BURST_LEN = 1,   // 1..BURST_LEN_MAX
  parameter int  ID_W      = $clog2(NUM_REQ)
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  fifo_rr_arbiter_if.master   bus
);

  localparam logic [ID_W-1:0]        LAST_RST = ID_W'(NUM_REQ - 1);
  localparam logic [BURST_CNT_W-1:0] CNT_ONE  = BURST_CNT_W'(1);

  logic                   in_valid_q, in_valid_d;
  PACKET_T                packet_q, packet_d;
  logic [ID_W-1:0]        grant_q, grant_d;
  logic [ID_W-1:0]        last_q, last_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic            load_en;
  logic            burst_done;
  logic            hold;
  logic            accept;
  logic            rr_found;
  logic [ID_W-1:0] rr_idx;
  logic [ID_W-1:0] start;
  logic [ID_W-1:0] sel;

  // Round-robin search origin: one past the last accepted requester.
  always_comb begin
    int start_int;
    start_int = wrap_inc(int'(last_q), NUM_REQ);
    start     = start_int[ID_W-1:0];
  end

  rr_pick #(
    .N (NUM_REQ),
    .W (ID_W)
  ) u_rr_pick (
    .req_i   (bus.req_valid),
    .start_i (start),
    .idx_o   (rr_idx),
    .found_o (rr_found)
  );

  assign load_en    = !in_valid_q || bus.in_ready;
  // burst_cnt saturates at BURST_LEN-1, so "done" is a simple compare.
  assign burst_done = int'(burst_cnt_q) >= (BURST_LEN - 1);
  assign hold       = bus.req_valid[last_q] && !burst_done;
  assign sel        = hold ? last_q : rr_idx;
  // rr_found is true whenever any request is valid, including the hold case.
  assign accept     = load_en && rr_found;

  // Ready decode depends only on handshake state, never on packet data.
  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = accept && (sel == ID_W'(i));
    end
  end

  always_comb begin
    in_valid_d  = in_valid_q;
    packet_d    = packet_q;
    grant_d     = grant_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    if (load_en) begin
      if (accept) begin
        in_valid_d = 1'b1;
        packet_d   = bus.req_packet[sel];
        grant_d    = sel;
        if (sel == last_q) begin
          // Saturate so a lone requester never wraps the count back into
          // hold range and starves the others when they arrive.
          if (!burst_done) begin
            burst_cnt_d = burst_cnt_q + CNT_ONE;
          end
        end else begin
          burst_cnt_d = '0;
          last_d      = sel;
        end
      end else begin
        // Nothing to load: the slot empties, data/id keep their old values.
        in_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      in_valid_q  <= 1'b0;
      packet_q    <= '0;
      grant_q     <= '0;
      last_q      <= LAST_RST;
      burst_cnt_q <= '0;
    end else begin
      in_valid_q  <= in_valid_d;
      packet_q    <= packet_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign bus.in_valid  = in_valid_q;
  assign bus.packet_in = packet_q;
  assign bus.grant_id  = grant_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Purpose : self-checking bench for fifo_rr_arbiter with BURST_LEN=1 and BURST_LEN=3 instances.
// Latency : checks one-cycle load and same-edge drain/load.
// Backpr. : drives in_ready low to check stall, random ready for the scoreboard run.
module tb_fifo_rr_arbiter;
  import fifo_arb_pkg::*;

  logic clock;
  logic reset_n;

  fifo_rr_arbiter_if #(.PACKET_T(logic [31:0]), .NUM_REQ(4)) if1 ();
  fifo_rr_arbiter_if #(.PACKET_T(logic [31:0]), .NUM_REQ(4)) if3 ();

  fifo_rr_arbiter #(.PACKET_T(logic [31:0]), .NUM_REQ(4), .BURST_LEN(1)) dut1 (
    .clock_i (clock), .reset_ni (reset_n), .bus (if1)
  );
  fifo_rr_arbiter #(.PACKET_T(logic [31:0]), .NUM_REQ(4), .BURST_LEN(3)) dut3 (
    .clock_i (clock), .reset_ni (reset_n), .bus (if3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Selected instance for table rows (0 = BURST_LEN 1, 1 = BURST_LEN 3).
  logic        cur;
  logic [3:0]  obs_rr;
  logic        obs_iv;
  logic [1:0]  obs_gid;
  logic [31:0] obs_pkt;

  always_comb begin
    if (cur) begin
      obs_rr = if3.req_ready; obs_iv = if3.in_valid; obs_gid = if3.grant_id; obs_pkt = if3.packet_in;
    end else begin
      obs_rr = if1.req_ready; obs_iv = if1.in_valid; obs_gid = if1.grant_id; obs_pkt = if1.packet_in;
    end
  end

  // Drive the selected instance; the other one idles and drains.
  task automatic drive(input logic [3:0] vld, input logic rdy);
    if (cur) begin
      if3.req_valid = vld;  if3.in_ready = rdy;
      if1.req_valid = 4'h0; if1.in_ready = 1'b1;
    end else begin
      if1.req_valid = vld;  if1.in_ready = rdy;
      if3.req_valid = 4'h0; if3.in_ready = 1'b1;
    end
  endtask

  typedef struct packed {
    logic       d3;
    logic [3:0] vld;
    logic       rdy;
    logic [3:0] exp_rr;
    logic       exp_iv;
    logic [1:0] exp_gid;
  } vec_t;

  vec_t tbl [21];

  // Scoreboard state for the random run on the BURST_LEN=3 instance.
  logic [31:0] sb [$];
  logic        pend [4];
  int          seq [4];
  int          wait_cnt [4];
  int          total_in;
  int          total_out;

  function automatic logic [31:0] mk_pkt(input int id, input int s);
    logic [7:0]  id8;
    logic [23:0] s24;
    id8 = id[7:0];
    s24 = s[23:0];
    return {id8, s24};
  endfunction

  task automatic sb_cycle(input bit allow_new, input bit force_rdy);
    logic [3:0]  acc;
    logic [31:0] exp;
    logic        legal;
    @(negedge clock);
    if (if3.in_valid && if3.in_ready) begin
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        check("sb_pkt", if3.packet_in, exp);
        check("sb_gid", 32'(if3.grant_id), 32'(exp[31:24]));
        total_out++;
      end
    end
    acc   = if3.req_ready;
    legal = ($countones(acc) <= 1) && ((acc & ~if3.req_valid) == 4'h0);
    check("sb_rr_legal", 32'(legal), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        sb.push_back(mk_pkt(i, seq[i]));
        total_in++;
        check($sformatf("fair_wait_req%0d", i), 32'(wait_cnt[i] <= 12), 32'd1);
        wait_cnt[i] = 0;
      end else if (acc != 4'h0 && if3.req_valid[i]) begin
        wait_cnt[i]++;
      end
    end
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        pend[i] = 1'b0;
        seq[i]++;
      end
      if (!pend[i] && allow_new && ($urandom_range(0, 2) == 0)) pend[i] = 1'b1;
      if3.req_valid[i]  = pend[i];
      if3.req_packet[i] = mk_pkt(i, seq[i]);
    end
    if3.in_ready = force_rdy ? 1'b1 : ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base;
    logic [31:0] exp;
    logic [31:0] q [$];
    int          c;

    //                d3   vld   rdy   rr    iv    gid
    tbl[0]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0};
    tbl[1]  = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1};
    tbl[2]  = '{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2};
    tbl[3]  = '{1'b0, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3};
    tbl[4]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0};
    tbl[5]  = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0};
    tbl[6]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0};
    tbl[7]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0};
    tbl[8]  = '{1'b0, 4'h4, 1'b0, 4'h4, 1'b1, 2'd2};
    tbl[9]  = '{1'b0, 4'hA, 1'b1, 4'h8, 1'b1, 2'd3};
    tbl[10] = '{1'b0, 4'hA, 1'b1, 4'h2, 1'b1, 2'd1};
    tbl[11] = '{1'b1, 4'h3, 1'b1, 4'h1, 1'b1, 2'd0};
    tbl[12] = '{1'b1, 4'h3, 1'b1, 4'h1, 1'b1, 2'd0};
    tbl[13] = '{1'b1, 4'h3, 1'b1, 4'h1, 1'b1, 2'd0};
    tbl[14] = '{1'b1, 4'h3, 1'b1, 4'h2, 1'b1, 2'd1};
    tbl[15] = '{1'b1, 4'h3, 1'b1, 4'h2, 1'b1, 2'd1};
    tbl[16] = '{1'b1, 4'h3, 1'b1, 4'h2, 1'b1, 2'd1};
    tbl[17] = '{1'b1, 4'h3, 1'b1, 4'h1, 1'b1, 2'd0};
    tbl[18] = '{1'b1, 4'h3, 1'b1, 4'h1, 1'b1, 2'd0};
    tbl[19] = '{1'b1, 4'h2, 1'b1, 4'h2, 1'b1, 2'd1};
    tbl[20] = '{1'b1, 4'h3, 1'b1, 4'h2, 1'b1, 2'd1};

    reset_n = 1'b0;
    cur     = 1'b0;
    drive(4'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if1.req_packet[i] = 32'h100 + 32'(i);
      if3.req_packet[i] = 32'h300 + 32'(i);
    end

    // Reset state.
    #12;
    check("rst_iv1",  32'(if1.in_valid),  32'd0);
    check("rst_pkt1", if1.packet_in,      32'd0);
    check("rst_gid1", 32'(if1.grant_id),  32'd0);
    check("rst_rr1",  32'(if1.req_ready), 32'd0);
    check("rst_iv3",  32'(if3.in_valid),  32'd0);
    #5 reset_n = 1'b1;

    // Table rows: round-robin, stall, idle, mid-burst drop, burst hold.
    @(posedge clock); #1;
    for (int k = 0; k < 21; k++) begin
      cur = tbl[k].d3;
      drive(tbl[k].vld, tbl[k].rdy);
      @(negedge clock);
      check($sformatf("tbl%0d_rr", k), 32'(obs_rr), 32'(tbl[k].exp_rr));
      @(posedge clock); #1;
      base = tbl[k].d3 ? 32'h300 : 32'h100;
      check($sformatf("tbl%0d_iv", k),  32'(obs_iv),  32'(tbl[k].exp_iv));
      check($sformatf("tbl%0d_gid", k), 32'(obs_gid), 32'(tbl[k].exp_gid));
      check($sformatf("tbl%0d_pkt", k), obs_pkt, base + 32'(tbl[k].exp_gid));
    end

    // Single requester streams back-to-back without bubbles.
    cur = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if1.req_packet[2] = 32'hA0 + 32'(k);
      q.push_back(32'hA0 + 32'(k));
      drive(4'h4, 1'b1);
      @(negedge clock);
      check($sformatf("strm%0d_rr", k), 32'(if1.req_ready), 32'h4);
      @(posedge clock); #1;
      exp = q.pop_front();
      check($sformatf("strm%0d_pkt", k), if1.packet_in, exp);
      check($sformatf("strm%0d_iv", k),  32'(if1.in_valid), 32'd1);
      check($sformatf("strm%0d_gid", k), 32'(if1.grant_id), 32'd2);
    end

    // FIFO full: hold 0x55 for five cycles, then resume in round-robin order.
    if1.req_packet[0] = 32'h55;
    drive(4'h1, 1'b1);
    @(negedge clock);
    check("stall_load_rr", 32'(if1.req_ready), 32'h1);
    @(posedge clock); #1;
    check("stall_load_pkt", if1.packet_in, 32'h55);
    for (int k = 0; k < 5; k++) begin
      drive(4'hF, 1'b0);
      @(negedge clock);
      check($sformatf("stall%0d_rr", k), 32'(if1.req_ready), 32'h0);
      @(posedge clock); #1;
      check($sformatf("stall%0d_pkt", k), if1.packet_in, 32'h55);
      check($sformatf("stall%0d_iv", k),  32'(if1.in_valid), 32'd1);
      check($sformatf("stall%0d_gid", k), 32'(if1.grant_id), 32'd0);
    end
    drive(4'hF, 1'b1);
    @(negedge clock);
    check("resume_rr", 32'(if1.req_ready), 32'h2);
    @(posedge clock); #1;
    check("resume_gid", 32'(if1.grant_id), 32'd1);
    check("resume_pkt", if1.packet_in, 32'h101);

    // Asynchronous reset while a packet is held.
    drive(4'hF, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    check("arst_iv",  32'(if1.in_valid), 32'd0);
    check("arst_gid", 32'(if1.grant_id), 32'd0);
    check("arst_pkt", if1.packet_in,     32'd0);
    drive(4'hA, 1'b1);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("arst_rel_rr", 32'(if1.req_ready), 32'h2);
    @(posedge clock); #1;
    check("arst_rel_gid", 32'(if1.grant_id), 32'd1);
    check("arst_rel_iv",  32'(if1.in_valid), 32'd1);

    // Random traffic on the BURST_LEN=3 instance against the scoreboard.
    cur = 1'b1;
    drive(4'h0, 1'b1);
    total_in  = 0;
    total_out = 0;
    for (int i = 0; i < 4; i++) begin
      pend[i]     = 1'b0;
      seq[i]      = 0;
      wait_cnt[i] = 0;
      if3.req_packet[i] = mk_pkt(i, 0);
    end
    for (int n = 0; n < 2000; n++) sb_cycle(1'b1, 1'b0);
    c = 0;
    while (c < 200 && (sb.size() != 0 || if3.in_valid || pend[0] || pend[1] || pend[2] || pend[3])) begin
      sb_cycle(1'b0, 1'b1);
      c++;
    end
    check("drain_done",  32'(c < 200), 32'd1);
    check("drain_empty", 32'(sb.size()), 32'd0);
    check("drain_count", 32'(total_out), 32'(total_in));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Round-robin arbiter that shares the input side of one FIFO among `NUM_REQ` valid/ready requesters. Each cycle it selects at most one requester, registers the winning packet and requester index into a one-entry output stage, and presents it on the FIFO's `in_valid`/`in_ready`/`packet_in` handshake. An optional burst limit lets one requester keep the grant for several consecutive beats. The block sits between the producer agents and the FIFO under test, and the FIFO-side handshake is identical to the FIFO's own input port.

## Interface
- `PACKET_T`, `logic [31:0]`: packet type, matching the FIFO's `PACKET_T`.
- `NUM_REQ`, 4: number of requesters; legal range 2..16.
- `BURST_LEN`, 1: maximum consecutive accepted beats per grant; legal range 1..16.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester index; derived, do not override.
- `clock` input 1: single clock; all state updates on posedge.
- `reset` input 1: asynchronous, active-low reset; 0 resets all state immediately.
- `req_valid` input `[NUM_REQ]`: requester i has a packet.
- `req_ready` output `[NUM_REQ]`: requester i's packet is accepted this cycle.
- `req_packet` input `PACKET_T [NUM_REQ]`: per-requester packet.
- `in_valid` output 1: connects to FIFO `in_valid`.
- `in_ready` input 1: connects to FIFO `in_ready`.
- `packet_in` output `PACKET_T`: connects to FIFO `packet_in`.
- `grant_id` output `ID_W`: index of the requester whose packet is on `packet_in`.

## Operation
- `load_en = !in_valid || in_ready`. The output stage accepts a new packet only when `load_en` is 1.
- Selection: if `load_en` is 1 and any `req_valid` is 1, choose one index `sel`. Then `req_ready[sel]=1` and every other `req_ready` bit is 0. When `load_en` is 0 or no request is valid, all `req_ready` bits are 0.
- Round-robin order: the search starts at `(last+1) mod NUM_REQ` and wraps around. `last` is the most recently accepted index.
- Burst hold: if `req_valid[last]=1` and `burst_cnt < BURST_LEN-1`, then `sel=last` and the round-robin search is skipped.
- `burst_cnt` rules on each accept:
  - `sel==last`: increment `burst_cnt`.
  - `sel!=last`: clear `burst_cnt` to 0 and set `last=sel`.
- With `BURST_LEN=1`, every accept rotates priority.
- On accept, register `packet_in <= req_packet[sel]`, `grant_id <= sel`, `in_valid <= 1`.
- If `load_en` is 1 and there is no request, `in_valid <= 0`. `packet_in` and `grant_id` keep their old values.
- Reset values: `in_valid=0`, `packet_in='0`, `grant_id=0`, `last=NUM_REQ-1` (so requester 0 wins first), `burst_cnt=0`.
- There is no explicit FSM. State is the output register, `last`, and `burst_cnt`.

## Timing
- Latency: a packet accepted at edge N is on `packet_in` with `in_valid=1` from N until the edge where `in_ready=1`.
- Throughput: one packet per cycle while `in_ready` stays 1.
- `req_ready` is combinational from `in_ready`, `in_valid`, `req_valid`, `last` and `burst_cnt`. `req_ready` has no combinational path from `req_packet`.
- While `in_valid=1` and `in_ready=0`: `packet_in` and `grant_id` stay stable, all `req_ready` bits are 0, and `last`/`burst_cnt` do not change.
- FIFO full (`in_ready` held 0): the arbiter holds one packet and back-pressures every requester. No packet is dropped or duplicated.
- Simultaneous drain and load: when `in_valid=1` and `in_ready=1`, the current packet leaves and the next one loads on the same edge, with no bubble.
- If a requester deasserts `req_valid` mid-burst, the grant moves on immediately and `burst_cnt` clears on the next accept.
- Reset asserted mid-transfer: outputs take their reset values asynchronously and any held packet is discarded. After release, requester 0 has top priority.

## Structure
- `fifo_arb_pkg`: `NUM_REQ_MAX=16`, `BURST_LEN_MAX=16`, and typedef `arb_id_t` sized for `NUM_REQ_MAX`.
- Sub-module `rr_pick`: purely combinational. Inputs are the request vector and the start index. Outputs are the first set index at or after start with wrap-around, plus a found flag. It is reused by future schedulers.
- The top level holds the output register, `last`, `burst_cnt`, and the ready decode.

## Test plan
- Reset, then all four `req_valid=1`, `in_ready=1`, `BURST_LEN=1` → `grant_id` sequence 0,1,2,3,0 on consecutive cycles, one `req_ready` bit per cycle.
- Only req 2 valid with packets 0xA0..0xA3, `in_ready=1` → `packet_in` shows 0xA0..0xA3 back-to-back, `grant_id=2`, with no bubbles.
- `BURST_LEN=3`, reqs 0 and 1 continuously valid → `grant_id` sequence 0,0,0,1,1,1,0.
- `in_ready=0` for 5 cycles with `packet_in=0x55`, `in_valid=1` → `packet_in` stays 0x55, all `req_ready=0`, and after `in_ready=1` the next grant follows round-robin order.
- `reset` pulsed low while `in_valid=1` → `in_valid` goes 0 without waiting for a clock edge, and after release with reqs 1 and 3 valid the first grant is 1.
- Random valid/ready traffic with a scoreboard → per-requester order is preserved, there is no loss or duplication, and no valid requester waits more than `NUM_REQ*BURST_LEN` accepts.
